// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb: round-robin arbiter between the subdrive track loaders and
// the single HPS SD image port. One transaction (track read or write-back) is
// in flight at a time. The granted channel's LBA and block count go to the HPS
// side, and the HPS ack, buffer write strobe and buffer read data are steered
// to and from that channel.
// Optional build macro: IEEEDRV_SDARB_TIMEOUT_EN adds a REQ/XFER watchdog and
// a sticky tmo_err output.
module ieeedrv_sd_arb #(
  parameter int SUBDRV = 2,
  parameter int BUF_AW = 14,
  parameter int TMO_W  = 24
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [SUBDRV-1:0][31:0] ch_lba,
  input  logic [SUBDRV-1:0][5:0]  ch_blk_cnt,
  input  logic [SUBDRV-1:0]       ch_rd,
  input  logic [SUBDRV-1:0]       ch_wr,
  output logic [SUBDRV-1:0]       ch_ack,
  input  logic [SUBDRV-1:0][7:0]  ch_buff_din,
  output logic [SUBDRV-1:0]       ch_buff_wr,
  output logic [31:0]             hps_lba,
  output logic [5:0]              hps_blk_cnt,
  output logic                    hps_rd,
  output logic                    hps_wr,
  input  logic                    hps_ack,
  input  logic [BUF_AW-1:0]       hps_buff_addr,
  input  logic                    hps_buff_wr,
  output logic [7:0]              hps_buff_din,
  output logic [1:0]              grant,
  output logic                    busy
`ifdef IEEEDRV_SDARB_TIMEOUT_EN
  ,
  output logic                    tmo_err
`endif
);

  localparam int IW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_GAP} state_t;

  state_t      state_reg;
  logic [1:0]  ptr_reg;
  logic [3:0]  pend;
  logic        hit;
  logic [1:0]  pick;
  int          rr_idx;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] grant_idx;
  logic        ack_win;
  logic        buf_win;
  logic        tmo_hit;
  logic        tmo_pulse;

  // The buffer address is broadcast to the loaders outside this block.
  logic unused_addr;
  assign unused_addr = ^hps_buff_addr;

  assign pick_idx  = pick[IW-1:0];
  assign grant_idx = grant[IW-1:0];
  assign ack_win   = (state_reg == ST_REQ) || (state_reg == ST_XFER);
  assign buf_win   = (state_reg == ST_XFER);

  // Round-robin search starting one past the last served channel; walking the
  // offsets downward lets the nearest pending channel win.
  always_comb begin
    pend = '0;
    pend[SUBDRV-1:0] = ch_rd | ch_wr;
    hit    = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int k = SUBDRV; k >= 1; k--) begin
      rr_idx = (int'(ptr_reg) + k) % SUBDRV;
      if (pend[rr_idx[1:0]]) begin
        hit  = 1'b1;
        pick = rr_idx[1:0];
      end
    end
  end

`ifdef IEEEDRV_SDARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_pulse_reg;

  assign tmo_hit   = ack_win && (&tmo_cnt_reg);
  assign tmo_pulse = tmo_pulse_reg;

  // Watchdog: held clear while idle, counts every REQ/XFER clock; a saturated
  // count aborts the transaction, gives the loader a one-cycle ack and latches tmo_err.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg   <= '0;
      tmo_pulse_reg <= 1'b0;
      tmo_err       <= 1'b0;
    end else begin
      tmo_pulse_reg <= tmo_hit;
      if (tmo_hit)
        tmo_err <= 1'b1;
      if (!ack_win)
        tmo_cnt_reg <= '0;
      else if (!tmo_hit)
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign tmo_hit    = 1'b0;
  assign tmo_pulse  = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, hold the request until ack, wait for ack
  // to fall, then one GAP cycle so the loader can drop its request.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      grant       <= '0;
      hps_lba     <= '0;
      hps_blk_cnt <= '0;
      hps_rd      <= 1'b0;
      hps_wr      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (hit) begin
            grant       <= pick;
            hps_lba     <= ch_lba[pick_idx];
            hps_blk_cnt <= ch_blk_cnt[pick_idx];
            if (ch_wr[pick_idx])
              hps_wr <= 1'b1;
            else
              hps_rd <= 1'b1;
            busy      <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (tmo_hit) begin
            hps_rd    <= 1'b0;
            hps_wr    <= 1'b0;
            ptr_reg   <= grant;
            busy      <= 1'b0;
            state_reg <= ST_GAP;
          end else if (hps_ack) begin
            hps_rd    <= 1'b0;
            hps_wr    <= 1'b0;
            state_reg <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (tmo_hit || !hps_ack) begin
            ptr_reg   <= grant;
            busy      <= 1'b0;
            state_reg <= ST_GAP;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-channel steering of the ack and buffer write strobe to the granted channel.
  for (genvar gi = 0; gi < SUBDRV; gi++) begin : g_ch
    assign ch_ack[gi]     = (grant == 2'(gi)) & ((ack_win & hps_ack) | tmo_pulse);
    assign ch_buff_wr[gi] = (grant == 2'(gi)) & buf_win & hps_buff_wr;
  end

  assign hps_buff_din = ch_buff_din[grant_idx];

endmodule
